fb_write_arbiter: RTL
=====================

// Module: fb_write_arbiter
// PURPOSE
//  Owns the single write port of the 1-bpp QQVGA (160x120) frame buffer. It shares the port
//  between two pixel-draw clients (A, B) using round-robin arbitration. It also runs an
//  internal full-screen clear sequence that takes priority over both clients. It sits between
//  the drawing engines and the frame-buffer RAM, which the VGA scan-out reads.
// PARAMETERS
//  ADDR_WIDTH  15   frame-buffer address width (2^15 >= 160*120)
//  H_RES       160  active pixels per line
//  V_RES       120  active lines per frame
//  X_WIDTH     8    client x-coordinate width
//  Y_WIDTH     7    client y-coordinate width
// PORTS
//  clk_25       in   1           pixel clock; all logic on rising edge
//  reset_n      in   1           asynchronous active-low reset
//  clear_start  in   1           1-cycle request: fill whole buffer with clear_value
//  clear_value  in   1           fill value, sampled with an accepted clear_start
//  clear_busy   out  1           high while the clear sequence is writing
//  a_valid      in   1           client A has a write pending
//  a_ready      out  1           client A write is accepted this cycle
//  a_x/a_y      in   X/Y_WIDTH   client A pixel coordinate
//  a_pixel      in   1           client A pixel value
//  b_valid, b_ready, b_x, b_y, b_pixel: same as client A
//  we           out  1           frame-buffer write enable (registered)
//  write_addr   out  ADDR_WIDTH  frame-buffer write address (registered)
//  pixel        out  1           frame-buffer write data (registered)
//  oob_err      out  1           1-cycle pulse: accepted write had an out-of-range coordinate
// BEHAVIOUR
//  - Reset (asynchronous): we=0, write_addr=0, pixel=0, clear_busy=0, oob_err=0, state=IDLE.
//    After reset, last_grant=B, so A wins the first contention.
//  - FSM has two states: IDLE and CLEAR.
//  - IDLE -> CLEAR when clear_start=1. Latch clear_value and load the clear counter with 0.
//  - CLEAR -> IDLE after the cycle that presents address H_RES*V_RES-1 (19199).
//  - clear_start is ignored while in CLEAR. It is not queued.
//  - Clear writes one pixel per cycle: we=1, pixel=latched value, write_addr=0,1,...,19199.
//    Address 0 is on the outputs the cycle after clear_start is sampled.
//    The clear takes exactly H_RES*V_RES cycles. clear_busy == (state==CLEAR), registered.
//  - Client handshake: a write transfers when valid & ready are both high on the same edge.
//    ready is combinational:
//    ready = (state==IDLE) & ~clear_start & (this client is the grant).
//    A client must hold valid, x, y and pixel stable until ready.
//  - Grant rules: if exactly one client is valid, it gets the grant. If both are valid, the
//    client other than last_grant gets it. last_grant updates only on a transfer.
//  - Client write latency is 1 cycle: a transfer at edge N puts we=1 and
//    write_addr = y*H_RES + x (computed in ADDR_WIDTH bits) on the outputs after edge N.
//    Max address is 19199, so there is no overflow.
//  - Out of range (x>=H_RES or y>=V_RES): the write is still accepted, so the client never
//    stalls. we stays 0 and oob_err=1 for one cycle.
//  - If clear_start and a client valid arrive in the same IDLE cycle, the clear wins and both
//    readies are 0. The client is served after the clear finishes.
//  - Cycles with no clear and no transfer: we=0. write_addr and pixel hold their last values.
//  - Throughput: one write per cycle. Back-to-back transfers are allowed, and alternate A/B
//    under sustained contention.
//  - Reset mid-clear aborts immediately. There is no resume, and the buffer is left partially
//    cleared.
// STRUCTURE
//  - Package fb_pkg: H_RES, V_RES, FB_DEPTH=H_RES*V_RES, ADDR_WIDTH, X_WIDTH, Y_WIDTH, state
//    enum {IDLE, CLEAR}, function xy_to_addr(x,y). The scan-out and drawing engines share it.
//  - Sub-module rr_arbiter2: 2-input round-robin. Inputs req[1:0] and advance; outputs a
//    one-hot grant[1:0]; holds the last_grant register.
//  - This module contains the FSM, clear counter, address multiply-add and output registers.
// TESTING
//  1. Reset, then clear_start=1 with clear_value=1 for 1 cycle -> next cycle we=1, addr 0,
//     pixel 1. Addresses increment by 1 for 19200 cycles, ending at 19199. Then clear_busy=0.
//  2. Only A valid with x=5, y=2, pixel=0 -> a_ready=1 at once. Next cycle we=1, addr 325,
//     pixel 0. b_ready stays 0.
//  3. A and B both valid for 6 cycles from reset -> grants go A,B,A,B,A,B. Each gets one we
//     pulse per grant with the correct address.
//  4. B valid with x=160, y=0 -> b_ready=1. Next cycle we=0 and oob_err=1. Same with
//     x=0, y=120.
//  5. clear_start and a_valid in the same cycle -> a_ready=0 for all 19200 clear cycles.
//     A is served the cycle after clear_busy falls. A clear_start mid-clear has no effect.
//  6. reset_n low at clear address 1000 -> outputs 0 asynchronously. After release,
//     state=IDLE and clear_busy=0.

Source files
------------

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
//   Shared constants and helpers for the 1-bpp QQVGA (160x120) frame buffer.
//   Used by the write arbiter, the drawing engines and the VGA scan-out so
//   that all of them agree on geometry and on the x/y -> address mapping.
//
//   Contents:
//     ADDR_WIDTH, H_RES, V_RES, FB_DEPTH, X_WIDTH, Y_WIDTH  geometry constants
//     LAST_ADDR                                             final buffer address
//     fb_state_e                                            write-port FSM states
//     xy_to_addr()                                          row-major address
//     xy_in_range()                                         coordinate bound test
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int ADDR_WIDTH = 15;   // 2^15 >= 160*120
  localparam int H_RES      = 160;  // active pixels per line
  localparam int V_RES      = 120;  // active lines per frame
  localparam int FB_DEPTH   = H_RES * V_RES;
  localparam int X_WIDTH    = 8;
  localparam int Y_WIDTH    = 7;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  // Row-major address. Evaluated in ADDR_WIDTH bits; for in-range
  // coordinates the result never exceeds LAST_ADDR, so nothing wraps.
  function automatic logic [ADDR_WIDTH-1:0] xy_to_addr(
    input logic [X_WIDTH-1:0] x,
    input logic [Y_WIDTH-1:0] y
  );
    return ADDR_WIDTH'(y) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(x);
  endfunction

  function automatic logic xy_in_range(
    input logic [X_WIDTH-1:0] x,
    input logic [Y_WIDTH-1:0] y
  );
    return (x < X_WIDTH'(H_RES)) && (y < Y_WIDTH'(V_RES));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-input round-robin arbiter. A lone requester always wins; under
//   contention the requester that did not win last time gets the grant.
//   The history register only moves when the owner reports a transfer.
//
//   Ports:
//     clk_25   in   pixel clock
//     reset_n  in   asynchronous active-low reset (history -> client 1)
//     req      in   [1:0] request vector, bit 0 = client A, bit 1 = client B
//     advance  in   a granted request transferred this cycle
//     grant    out  [1:0] one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk_25,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 0 = client A won last, 1 = client B won last. Resetting to B makes A
  // the winner of the first contention.
  logic last_grant;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// fb_write_arbiter
//   Owner of the single frame-buffer write port. Shares it between two
//   pixel-draw clients with round-robin arbitration and runs a full-screen
//   clear that pre-empts both clients. All port outputs are registered, so a
//   client transfer appears on the write port one cycle later.
//
//   Ports:
//     clk_25, reset_n              pixel clock, async active-low reset
//     clear_start, clear_value     one-cycle clear request and its fill value
//     clear_busy                   clear sequence is writing
//     a_valid/a_ready/a_x/a_y/a_pixel   client A valid/ready write channel
//     b_valid/b_ready/b_x/b_y/b_pixel   client B valid/ready write channel
//     we, write_addr, pixel        registered frame-buffer write port
//     oob_err                      one-cycle pulse: accepted write was off-screen
// ---------------------------------------------------------------------------
module fb_write_arbiter
  import fb_pkg::*;
(
  input  logic                  clk_25,
  input  logic                  reset_n,

  input  logic                  clear_start,
  input  logic                  clear_value,
  output logic                  clear_busy,

  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [X_WIDTH-1:0]    a_x,
  input  logic [Y_WIDTH-1:0]    a_y,
  input  logic                  a_pixel,

  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [X_WIDTH-1:0]    b_x,
  input  logic [Y_WIDTH-1:0]    b_y,
  input  logic                  b_pixel,

  output logic                  we,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  pixel,
  output logic                  oob_err
);

  fb_state_e             state;
  logic [ADDR_WIDTH-1:0] clear_cnt;   // address currently presented by the clear
  logic                  clear_val;   // fill value latched at clear_start

  logic [1:0]            grant;
  logic                  port_free;
  logic                  a_xfer;
  logic                  b_xfer;
  logic                  xfer;

  logic [X_WIDTH-1:0]    sel_x;
  logic [Y_WIDTH-1:0]    sel_y;
  logic                  sel_pixel;

  // -------------------------------------------------------------------------
  // Arbitration and handshake
  // -------------------------------------------------------------------------
  rr_arbiter2 u_arb (
    .clk_25  (clk_25),
    .reset_n (reset_n),
    .req     ({b_valid, a_valid}),
    .advance (xfer),
    .grant   (grant)
  );

  // A clear request in the same cycle takes the port, so clients are held
  // off combinationally and get served once the clear has finished.
  assign port_free = (state == IDLE) && !clear_start;
  assign a_ready   = port_free && grant[0];
  assign b_ready   = port_free && grant[1];

  assign a_xfer    = a_valid && a_ready;
  assign b_xfer    = b_valid && b_ready;
  assign xfer      = a_xfer || b_xfer;

  // Grant is one-hot, so at most one client transfers; pick its payload.
  always_comb begin
    sel_x     = a_x;
    sel_y     = a_y;
    sel_pixel = a_pixel;
    if (b_xfer) begin
      sel_x     = b_x;
      sel_y     = b_y;
      sel_pixel = b_pixel;
    end
  end

  // -------------------------------------------------------------------------
  // FSM, clear counter and registered write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      clear_cnt  <= '0;
      clear_val  <= 1'b0;
      clear_busy <= 1'b0;
      we         <= 1'b0;
      write_addr <= '0;
      pixel      <= 1'b0;
      oob_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            // Present address 0 straight away so the clear spans exactly
            // FB_DEPTH cycles of write-port activity.
            state      <= CLEAR;
            clear_cnt  <= '0;
            clear_val  <= clear_value;
            clear_busy <= 1'b1;
            we         <= 1'b1;
            write_addr <= '0;
            pixel      <= clear_value;
            oob_err    <= 1'b0;
          end else if (xfer) begin
            // Off-screen writes are still accepted so a client never stalls;
            // they only raise oob_err and leave the port idle.
            if (xy_in_range(sel_x, sel_y)) begin
              we         <= 1'b1;
              write_addr <= xy_to_addr(sel_x, sel_y);
              pixel      <= sel_pixel;
              oob_err    <= 1'b0;
            end else begin
              we         <= 1'b0;
              oob_err    <= 1'b1;
            end
          end else begin
            // Idle cycle: address and data hold their last values.
            we      <= 1'b0;
            oob_err <= 1'b0;
          end
        end

        CLEAR: begin
          oob_err <= 1'b0;
          if (clear_cnt == LAST_ADDR) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
            we         <= 1'b0;
          end else begin
            clear_cnt  <= clear_cnt + 1'b1;
            write_addr <= clear_cnt + 1'b1;
            pixel      <= clear_val;
            we         <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          clear_busy <= 1'b0;
          we         <= 1'b0;
          oob_err    <= 1'b0;
        end
      endcase
    end
  end

endmodule
